memory_ack_responder: RTL and testbench

Memory-side responder for the RD/WR/ACK request handshake that the control unit (`Centro_Control`) issues toward main memory. It accepts one read or one write request at a time and holds a synchronous word-addressed storage array. After a fixed, parameterised latency it performs the access. It returns ACK using a four-phase (level) handshake, so the control unit's ACK input can be driven by a real responder.

---
 rtl/memory_ack_responder.sv | 102 ++++++++++
 tb/tb_memory_ack_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/memory_ack_responder.sv
// Memory-side responder for the RD/WR/ACK four-phase handshake.
// Performs one access after a fixed latency and holds ACK until both requests drop.
module memory_ack_responder #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int LATENCY       = 2
) (
  input  logic                     MEMORY_RESPONDER_CLOCK_50,
  input  logic                     MEMORY_RESPONDER_RESET_InHigh,
  input  logic                     MEMORY_RESPONDER_RD_In,
  input  logic                     MEMORY_RESPONDER_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_RESPONDER_data_OutBUS,
  output logic                     MEMORY_RESPONDER_ACK_Out,
  output logic                     MEMORY_RESPONDER_ERR_Out
);

  // state | meaning
  // IDLE  | waiting for a single RD or WR request
  // BUSY  | latency countdown on captured address/data/op
  // ACKW  | access done, ACK high until both requests drop
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACKW = 2'd2;

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]               state;
  logic [3:0]               count;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATAWIDTH_BUS-1:0] data_q;
  logic                     write_q;
  logic [DATAWIDTH_BUS-1:0] mem [0:DEPTH-1];

  logic clk;
  logic rst;
  logic rd;
  logic wr;
  logic access_now;
  logic unused_addr_bits;

  assign clk = MEMORY_RESPONDER_CLOCK_50;
  assign rst = MEMORY_RESPONDER_RESET_InHigh;
  assign rd  = MEMORY_RESPONDER_RD_In;
  assign wr  = MEMORY_RESPONDER_WR_In;

  // Upper address bits are discarded on purpose so addresses wrap onto the array.
  assign unused_addr_bits = ^MEMORY_RESPONDER_ADDRESS_InBUS[DATAWIDTH_BUS-1:ADDR_WIDTH];

  assign access_now = (state == BUSY) && (count == 4'd0);
  assign MEMORY_RESPONDER_ACK_Out = (state == ACKW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                        <= IDLE;
      count                        <= 4'd0;
      addr_q                       <= '0;
      data_q                       <= '0;
      write_q                      <= 1'b0;
      MEMORY_RESPONDER_ERR_Out     <= 1'b0;
      MEMORY_RESPONDER_data_OutBUS <= '0;
    end else begin
      case (state)
        IDLE: begin
          MEMORY_RESPONDER_ERR_Out <= rd & wr;
          if (rd ^ wr) begin
            addr_q  <= MEMORY_RESPONDER_ADDRESS_InBUS[ADDR_WIDTH-1:0];
            data_q  <= MEMORY_RESPONDER_data_InBUS;
            write_q <= wr;
            count   <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          MEMORY_RESPONDER_ERR_Out <= 1'b0;
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (!write_q) MEMORY_RESPONDER_data_OutBUS <= mem[addr_q];
            state <= ACKW;
          end
        end
        ACKW: begin
          MEMORY_RESPONDER_ERR_Out <= 1'b0;
          if (!rd && !wr) state <= IDLE;
        end
        default: begin
          MEMORY_RESPONDER_ERR_Out <= 1'b0;
          state                    <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset; a reset edge still blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && access_now && write_q) mem[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_memory_ack_responder.sv
// Directed bench for memory_ack_responder with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_memory_ack_responder;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  memory_ack_responder #(
    .DATAWIDTH_BUS(32),
    .ADDR_WIDTH(8),
    .LATENCY(2)
  ) dut (
    .MEMORY_RESPONDER_CLOCK_50     (clk),
    .MEMORY_RESPONDER_RESET_InHigh (rst),
    .MEMORY_RESPONDER_RD_In        (rd),
    .MEMORY_RESPONDER_WR_In        (wr),
    .MEMORY_RESPONDER_ADDRESS_InBUS(addr),
    .MEMORY_RESPONDER_data_InBUS   (din),
    .MEMORY_RESPONDER_data_OutBUS  (dout),
    .MEMORY_RESPONDER_ACK_Out      (ack),
    .MEMORY_RESPONDER_ERR_Out      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write with LATENCY=2: ACK expected after the third edge.
  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; din = d;
    step(); step(); step();
    check("wr_ack_high", {31'd0, ack}, 32'd1);
    wr = 1'b0;
    step();
    check("wr_ack_low", {31'd0, ack}, 32'd0);
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    step(); step(); step();
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check({tag, "_data"}, dout, exp);
    rd = 1'b0;
    step();
    check({tag, "_ack_low"}, {31'd0, ack}, 32'd0);
    check({tag, "_data_hold"}, dout, exp);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h0; din = 32'h0;

    // Reset held two cycles with RD high
    step(); step();
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dout", dout, 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_e1_ack", {31'd0, ack}, 32'd0);
    step();
    check("post_rst_e2_ack", {31'd0, ack}, 32'd0);
    step();
    check("post_rst_e3_ack", {31'd0, ack}, 32'd1);
    rd = 1'b0;
    step();
    check("post_rst_release", {31'd0, ack}, 32'd0);

    // Write then read, with edge-by-edge ACK timing
    wr = 1'b1; addr = 32'h05; din = 32'hDEADBEEF;
    step();
    check("wr1_e1_ack", {31'd0, ack}, 32'd0);
    step();
    check("wr1_e2_ack", {31'd0, ack}, 32'd0);
    step();
    check("wr1_e3_ack", {31'd0, ack}, 32'd1);
    wr = 1'b0;
    step();
    check("wr1_ack_fall", {31'd0, ack}, 32'd0);
    read_word("rd1", 32'h05, 32'hDEADBEEF);

    // Address wrap and capture during BUSY
    wr = 1'b1; addr = 32'h105; din = 32'h12345678;
    step();
    addr = 32'h07; din = 32'h0;
    step(); step();
    check("wrap_ack", {31'd0, ack}, 32'd1);
    wr = 1'b0;
    step();
    rd = 1'b1; addr = 32'h05;
    step();
    addr = 32'h07;
    step(); step();
    check("capture_ack", {31'd0, ack}, 32'd1);
    check("capture_data", dout, 32'h12345678);
    rd = 1'b0;
    step();

    // Conflict: both requests for three cycles
    write_word(32'h20, 32'hCAFEF00D);
    rd = 1'b1; wr = 1'b1; addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      step();
      check("conflict_err", {31'd0, err}, 32'd1);
      check("conflict_ack", {31'd0, ack}, 32'd0);
    end
    check("conflict_dout_hold", dout, 32'h12345678);
    wr = 1'b0;
    step();
    check("conflict_err_clear", {31'd0, err}, 32'd0);
    step(); step();
    check("conflict_rd_ack", {31'd0, ack}, 32'd1);
    check("conflict_rd_data", dout, 32'hCAFEF00D);
    rd = 1'b0;
    step();

    // Early drop: WR held one cycle only
    wr = 1'b1; addr = 32'h30; din = 32'h0BADF00D;
    step();
    wr = 1'b0;
    step();
    check("early_e2_ack", {31'd0, ack}, 32'd0);
    step();
    check("early_pulse_high", {31'd0, ack}, 32'd1);
    step();
    check("early_pulse_low", {31'd0, ack}, 32'd0);
    read_word("early_rd", 32'h30, 32'h0BADF00D);

    // Reset during BUSY suppresses the pending write
    write_word(32'h40, 32'h11112222);
    wr = 1'b1; addr = 32'h40; din = 32'hAAAA5555;
    step();
    rst = 1'b1;
    step();
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_dout", dout, 32'h0);
    rst = 1'b0; wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_no_ack", {31'd0, ack}, 32'd0);
    end
    read_word("midrst_rd", 32'h40, 32'h11112222);
    read_word("final_rd5", 32'h05, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
